// File: rtl/phy_dly_loader.sv
// PHY delay-programming sequencer: shadow table of per-line delays,
// streamed to the PHY delay-load port on start, followed by a set strobe.
module phy_dly_loader #(
  parameter int         NUM_DLY    = 96,
  parameter logic [7:0] DLY_INIT   = 8'h00,
  parameter int         SET_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_in,
  input  logic       wr_en,
  input  logic [6:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  input  logic       start,
  input  logic       force_all,
  output logic       busy,
  output logic       done,
  output logic [6:0] dly_addr,
  output logic [7:0] dly_data,
  output logic       ld_delay,
  output logic       set
);

  localparam logic [7:0] NUM_N  = 8'(NUM_DLY);
  localparam logic [6:0] LAST   = 7'(NUM_DLY - 1);
  localparam logic [7:0] SET_N  = 8'(SET_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SETP = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic       force_q, force_d;
  logic       set_d, done_d;
  logic       scan;

  logic [7:0]         tbl [NUM_DLY];
  logic [NUM_DLY-1:0] dirty;

  assign scan = (state_q == SCAN);

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      force_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      force_q <= force_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    force_d = force_q;
    set_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          idx_d   = '0;
          force_d = force_all;
        end
      end
      SCAN: begin
        idx_d = idx_q + 7'd1;
        if (idx_q == LAST) begin
          state_d = SETP;
          cnt_d   = '0;
        end
      end
      SETP: begin
        if (cnt_q < SET_N) begin
          set_d = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A host write to the entry being scanned wins: its dirty bit survives.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_DLY; i++) begin
        tbl[i] <= DLY_INIT;
      end
      dirty <= '1;
    end else begin
      for (int i = 0; i < NUM_DLY; i++) begin
        if (wr_en && wr_addr == 7'(i)) begin
          tbl[i]   <= wr_data;
          dirty[i] <= 1'b1;
        end else if (scan && idx_q == 7'(i)) begin
          dirty[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      set      <= 1'b0;
      ld_delay <= 1'b0;
      dly_addr <= '0;
      dly_data <= '0;
    end else begin
      busy <= (state_d != IDLE);
      done <= done_d;
      set  <= set_d;
      if (scan) begin
        dly_addr <= idx_q;
        dly_data <= tbl[idx_q];
        ld_delay <= dirty[idx_q] | force_q;
      end else begin
        ld_delay <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      rd_data <= '0;
    end else if ({1'b0, rd_addr} < NUM_N) begin
      rd_data <= tbl[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_phy_dly_loader.sv
// Directed bench for phy_dly_loader: load runs, dirty tracking,
// in-run writes, set/done timing and mid-run reset.
module tb_phy_dly_loader;

  logic       clk = 1'b0;
  logic       rst_in;
  logic       wr_en;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic       start;
  logic       force_all;
  logic       busy;
  logic       done;
  logic [6:0] dly_addr;
  logic [7:0] dly_data;
  logic       ld_delay;
  logic       set;

  int checks = 0;
  int failures = 0;

  int         lq_k[$];
  logic [6:0] lq_a[$];
  logic [7:0] lq_d[$];
  int         addr_err;
  logic [7:0] data_or;

  phy_dly_loader dut (
    .clk(clk), .rst_in(rst_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .start(start), .force_all(force_all),
    .busy(busy), .done(done),
    .dly_addr(dly_addr), .dly_data(dly_data),
    .ld_delay(ld_delay), .set(set)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // k0/k1: scan index at whose edge a host write lands (-1 none)
  // sk: scan index at whose edge a stray start is raised (-1 none)
  task automatic run(input logic frc,
                     input int k0, input logic [6:0] a0, input logic [7:0] d0,
                     input int k1, input logic [6:0] a1, input logic [7:0] d1,
                     input int sk);
    lq_k.delete(); lq_a.delete(); lq_d.delete();
    addr_err = 0;
    data_or = 8'h00;
    start = 1'b1; force_all = frc;
    tick();
    start = 1'b0; force_all = 1'b0;
    chk("busy_T+1", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 96; k++) begin
      wr_en = 1'b0;
      if (k == k0) begin wr_en = 1'b1; wr_addr = a0; wr_data = d0; end
      if (k == k1) begin wr_en = 1'b1; wr_addr = a1; wr_data = d1; end
      start = (k == sk);
      tick();
      wr_en = 1'b0; start = 1'b0;
      if (dly_addr !== 7'(k)) addr_err++;
      if (ld_delay === 1'b1) begin
        lq_k.push_back(k); lq_a.push_back(dly_addr);
        lq_d.push_back(dly_data);
        data_or = data_or | dly_data;
      end
    end
    chk("dly_addr_seq", addr_err, 0);
    tick();
    chk("set_T+98", {31'd0, set}, 32'd1);
    chk("ld_T+98", {31'd0, ld_delay}, 32'd0);
    tick();
    chk("set_T+99", {31'd0, set}, 32'd1);
    chk("done_T+99", {31'd0, done}, 32'd0);
    tick();
    chk("done_T+100", {31'd0, done}, 32'd1);
    chk("busy_T+100", {31'd0, busy}, 32'd0);
    chk("set_T+100", {31'd0, set}, 32'd0);
    tick();
    chk("done_T+101", {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst_in = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; start = 1'b0; force_all = 1'b0;
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ld", {31'd0, ld_delay}, 32'd0);
    chk("rst_set", {31'd0, set}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_addr", {25'd0, dly_addr}, 32'd0);
    chk("rst_rd", {24'd0, rd_data}, 32'd0);
    rst_in = 1'b0;
    tick();

    // run 1: everything dirty after reset
    run(1'b0, -1, 0, 0, -1, 0, 0, -1);
    chk("r1_count", lq_a.size(), 96);
    chk("r1_data_or", {24'd0, data_or}, 32'd0);
    chk("r1_first", {25'd0, lq_a[0]}, 32'd0);
    chk("r1_last", {25'd0, lq_a[95]}, 32'd95);

    // host writes, read-back, out-of-range write ignored
    wr(7'd5, 8'h3A);
    wr(7'd40, 8'h11);
    wr(7'd100, 8'hFF);
    rd_addr = 7'd5; tick();
    chk("rd_5", {24'd0, rd_data}, 32'h3A);
    rd_addr = 7'd100; tick();
    chk("rd_oor", {24'd0, rd_data}, 32'd0);

    // run 2: only the two dirty entries
    run(1'b0, -1, 0, 0, -1, 0, 0, -1);
    chk("r2_count", lq_a.size(), 2);
    chk("r2_k0", lq_k[0], 5);
    chk("r2_a0", {25'd0, lq_a[0]}, 32'd5);
    chk("r2_d0", {24'd0, lq_d[0]}, 32'h3A);
    chk("r2_k1", lq_k[1], 40);
    chk("r2_d1", {24'd0, lq_d[1]}, 32'h11);

    // run 3: nothing dirty; run 4: forced
    run(1'b0, -1, 0, 0, -1, 0, 0, -1);
    chk("r3_count", lq_a.size(), 0);
    run(1'b1, -1, 0, 0, -1, 0, 0, -1);
    chk("r4_count", lq_a.size(), 96);

    // run 5: write [70] ahead of scan, [3] behind scan
    run(1'b0, 9, 7'd70, 8'h55, 10, 7'd3, 8'h66, -1);
    chk("r5_count", lq_a.size(), 1);
    chk("r5_k", lq_k[0], 70);
    chk("r5_d", {24'd0, lq_d[0]}, 32'h55);

    // run 6: [3] from last run, write collides with scan of [20],
    // plus a start while busy
    wr(7'd20, 8'h21);
    run(1'b0, 20, 7'd20, 8'h77, -1, 0, 0, 50);
    chk("r6_count", lq_a.size(), 2);
    chk("r6_a0", {25'd0, lq_a[0]}, 32'd3);
    chk("r6_d0", {24'd0, lq_d[0]}, 32'h66);
    chk("r6_a1", {25'd0, lq_a[1]}, 32'd20);
    chk("r6_d1", {24'd0, lq_d[1]}, 32'h21);
    tick(); tick();
    chk("busy_start_ignored", {31'd0, busy}, 32'd0);

    // run 7: collided entry reloaded with new value
    run(1'b0, -1, 0, 0, -1, 0, 0, -1);
    chk("r7_count", lq_a.size(), 1);
    chk("r7_a", {25'd0, lq_a[0]}, 32'd20);
    chk("r7_d", {24'd0, lq_d[0]}, 32'h77);

    // mid-run reset
    wr(7'd7, 8'h99);
    start = 1'b1; tick(); start = 1'b0;
    repeat (28) tick();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_in = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ld", {31'd0, ld_delay}, 32'd0);
    tick();
    chk("mid_rst_set", {31'd0, set}, 32'd0);
    rst_in = 1'b0;
    rd_addr = 7'd7; tick();
    chk("rd_after_rst", {24'd0, rd_data}, 32'd0);
    run(1'b0, -1, 0, 0, -1, 0, 0, -1);
    chk("r8_count", lq_a.size(), 96);
    chk("r8_data_or", {24'd0, data_or}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
